// File: rtl/hazard_ctrl_md_pkg.sv
// Shared definitions for the MIPS hazard unit: forwarding-select encodings
// and the default multiply/divide busy latencies.
package hazard_ctrl_md_pkg;

  typedef enum logic [1:0] {
    FW_GRF = 2'd0,
    FW_W   = 2'd1,
    FW_M   = 2'd2,
    FW_E   = 2'd3
  } fw_sel_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_if.sv
// Decoder-to-hazard-unit bundle: per-stage register addresses and timing in,
// stall/forwarding controls and MD status out.
interface hazard_ctrl_md_if #(
  parameter int REG_W  = 5,
  parameter int T_W    = 2,
  parameter int PERF_W = 32
);
  logic [REG_W-1:0]  D_A1;
  logic [REG_W-1:0]  D_A2;
  logic [T_W-1:0]    D_rs_Tuse;
  logic [T_W-1:0]    D_rt_Tuse;
  logic              D_md_use;
  logic [REG_W-1:0]  E_A1;
  logic [REG_W-1:0]  E_A2;
  logic [REG_W-1:0]  E_A3;
  logic [T_W-1:0]    E_Tnew;
  logic              E_md_start;
  logic              E_md_div;
  logic [REG_W-1:0]  M_A2;
  logic [REG_W-1:0]  M_A3;
  logic [T_W-1:0]    M_Tnew;
  logic [REG_W-1:0]  W_A3;

  logic              Stall;
  logic              E_flush;
  logic [1:0]        FW_D_rs;
  logic [1:0]        FW_D_rt;
  logic [1:0]        FW_E_rs;
  logic [1:0]        FW_E_rt;
  logic              FW_M_rt;
  logic              md_busy;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output D_A1, D_A2, D_rs_Tuse, D_rt_Tuse, D_md_use,
           E_A1, E_A2, E_A3, E_Tnew, E_md_start, E_md_div,
           M_A2, M_A3, M_Tnew, W_A3,
    input  Stall, E_flush, FW_D_rs, FW_D_rt, FW_E_rs, FW_E_rt, FW_M_rt,
           md_busy, stall_cnt
  );

  modport slave (
    input  D_A1, D_A2, D_rs_Tuse, D_rt_Tuse, D_md_use,
           E_A1, E_A2, E_A3, E_Tnew, E_md_start, E_md_div,
           M_A2, M_A3, M_Tnew, W_A3,
    output Stall, E_flush, FW_D_rs, FW_D_rt, FW_E_rs, FW_E_rt, FW_M_rt,
           md_busy, stall_cnt
  );

endinterface

// File: rtl/hazard_ctrl_md_md_busy_counter.sv
// Multiply/divide occupancy tracker: loads the op latency when an MD op
// leaves E and counts down to idle.
module md_busy_counter
  import hazard_ctrl_md_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_V = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_V  = CNT_W'(DIV_LAT);

  if ((2 ** CNT_W) - 1 < max_lat(MULT_LAT, DIV_LAT)) begin : g_cnt_w_too_small
    $error("md_busy_counter: CNT_W too narrow for the configured latencies");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A new start always reloads, even if a previous op is still counting.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = is_div ? DIV_V : MULT_V;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = start | (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl_md.sv
// Pipeline hazard unit for the 5-stage MIPS core: Tuse/Tnew stall, forwarding
// selects, MD busy stall and a saturating stall-cycle counter.
module hazard_ctrl_md
  import hazard_ctrl_md_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int T_W      = 2,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4,
  parameter int PERF_W   = 32
) (
  input  logic           clk,
  input  logic           reset,
  hazard_ctrl_md_if.slave hz
);

  logic [REG_W-1:0] d_a1, d_a2, e_a1, e_a2, e_a3, m_a2, m_a3, w_a3;
  logic [T_W-1:0]   d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;

  assign d_a1      = hz.D_A1;
  assign d_a2      = hz.D_A2;
  assign e_a1      = hz.E_A1;
  assign e_a2      = hz.E_A2;
  assign e_a3      = hz.E_A3;
  assign m_a2      = hz.M_A2;
  assign m_a3      = hz.M_A3;
  assign w_a3      = hz.W_A3;
  assign d_rs_tuse = hz.D_rs_Tuse;
  assign d_rt_tuse = hz.D_rt_Tuse;
  assign e_tnew    = hz.E_Tnew;
  assign m_tnew    = hz.M_Tnew;

  // $0 is hard-wired, so it never creates a dependency.
  function automatic logic hit(input logic [REG_W-1:0] a3,
                               input logic [REG_W-1:0] addr);
    return (a3 == addr) && (addr != '0);
  endfunction

  function automatic fw_sel_e fw_d_sel(input logic [REG_W-1:0] addr);
    fw_sel_e sel;
    sel = FW_GRF;
    if (hit(e_a3, addr) && (e_tnew == '0)) begin
      sel = FW_E;
    end else if (hit(m_a3, addr) && (m_tnew == '0)) begin
      sel = FW_M;
    end else if (hit(w_a3, addr)) begin
      sel = FW_W;
    end
    return sel;
  endfunction

  function automatic fw_sel_e fw_e_sel(input logic [REG_W-1:0] addr);
    fw_sel_e sel;
    sel = FW_GRF;
    if (hit(m_a3, addr) && (m_tnew == '0)) begin
      sel = FW_M;
    end else if (hit(w_a3, addr)) begin
      sel = FW_W;
    end
    return sel;
  endfunction

  logic    reg_stall, md_stall, stall, md_busy_raw;
  fw_sel_e fw_d_rs, fw_d_rt, fw_e_rs, fw_e_rt;
  logic    fw_m_rt;

  always_comb begin
    reg_stall = (hit(e_a3, d_a1) && (e_tnew > d_rs_tuse)) ||
                (hit(m_a3, d_a1) && (m_tnew > d_rs_tuse)) ||
                (hit(e_a3, d_a2) && (e_tnew > d_rt_tuse)) ||
                (hit(m_a3, d_a2) && (m_tnew > d_rt_tuse));
    fw_d_rs   = fw_d_sel(d_a1);
    fw_d_rt   = fw_d_sel(d_a2);
    fw_e_rs   = fw_e_sel(e_a1);
    fw_e_rt   = fw_e_sel(e_a2);
    fw_m_rt   = hit(w_a3, m_a2);
  end

  md_busy_counter #(
    .CNT_W   (CNT_W),
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy (
    .clk   (clk),
    .reset (reset),
    .start (hz.E_md_start),
    .is_div(hz.E_md_div),
    .busy  (md_busy_raw)
  );

  assign md_stall = hz.D_md_use & md_busy_raw;
  assign stall    = reset & (reg_stall | md_stall);

  // All controls read as idle while reset is held low.
  assign hz.Stall   = stall;
  assign hz.E_flush = stall;
  assign hz.md_busy = reset & md_busy_raw;
  assign hz.FW_D_rs = reset ? fw_d_rs : FW_GRF;
  assign hz.FW_D_rt = reset ? fw_d_rt : FW_GRF;
  assign hz.FW_E_rs = reset ? fw_e_rs : FW_GRF;
  assign hz.FW_E_rt = reset ? fw_e_rt : FW_GRF;
  assign hz.FW_M_rt = reset & fw_m_rt;

  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// Scoreboard bench for hazard_ctrl_md: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl_md;
  import hazard_ctrl_md_pkg::*;

  localparam int F_STALL = 0;
  localparam int F_FLUSH = 1;
  localparam int F_FWDRS = 2;
  localparam int F_FWDRT = 3;
  localparam int F_FWERS = 4;
  localparam int F_FWERT = 5;
  localparam int F_FWMRT = 6;
  localparam int F_BUSY  = 7;
  localparam int F_CNT   = 8;

  typedef struct {
    string tag;
    int    fld;
    int    val;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl_md_if #(.REG_W(5), .T_W(2), .PERF_W(4)) hif ();

  hazard_ctrl_md #(.PERF_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hif)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int obs_fld(input int f);
    case (f)
      F_STALL: return int'(hif.Stall);
      F_FLUSH: return int'(hif.E_flush);
      F_FWDRS: return int'(hif.FW_D_rs);
      F_FWDRT: return int'(hif.FW_D_rt);
      F_FWERS: return int'(hif.FW_E_rs);
      F_FWERT: return int'(hif.FW_E_rt);
      F_FWMRT: return int'(hif.FW_M_rt);
      F_BUSY:  return int'(hif.md_busy);
      default: return int'(hif.stall_cnt);
    endcase
  endfunction

  function automatic void expect_out(input string tag, input int f, input int v);
    exp_t e;
    e.tag = tag;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs_fld(e.fld), e.val);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hif.D_A1 = '0; hif.D_A2 = '0; hif.D_rs_Tuse = '0; hif.D_rt_Tuse = '0;
    hif.D_md_use = 1'b0; hif.E_A1 = '0; hif.E_A2 = '0; hif.E_A3 = '0;
    hif.E_Tnew = '0; hif.E_md_start = 1'b0; hif.E_md_div = 1'b0;
    hif.M_A2 = '0; hif.M_A3 = '0; hif.M_Tnew = '0; hif.W_A3 = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    idle();
    reset = 1'b0;

    // held in reset with hazards present on the inputs
    cyc();
    hif.E_A3 = 5'd8; hif.E_Tnew = 2'd2; hif.D_A1 = 5'd8;
    hif.M_A2 = 5'd3; hif.W_A3 = 5'd3;
    hif.E_md_start = 1'b1; hif.D_md_use = 1'b1;
    expect_out("rst_stall", F_STALL, 0);
    expect_out("rst_flush", F_FLUSH, 0);
    expect_out("rst_busy",  F_BUSY,  0);
    expect_out("rst_fwmrt", F_FWMRT, 0);
    expect_out("rst_fwdrs", F_FWDRS, 0);
    cyc();
    idle();
    expect_out("rst_cnt", F_CNT, 0);

    // lw in E, then M, then W, consumer with Tuse 0
    cyc(); reset = 1'b1; idle();
    hif.E_A3 = 5'd8; hif.E_Tnew = 2'd2; hif.D_A1 = 5'd8;
    expect_out("t1_e_stall", F_STALL, 1);
    expect_out("t1_e_flush", F_FLUSH, 1);
    expect_out("t1_e_fw",    F_FWDRS, 0);
    cyc(); idle();
    hif.M_A3 = 5'd8; hif.M_Tnew = 2'd1; hif.D_A1 = 5'd8;
    expect_out("t1_m_stall", F_STALL, 1);
    expect_out("t1_m_fw",    F_FWDRS, 0);
    cyc(); idle();
    hif.W_A3 = 5'd8; hif.D_A1 = 5'd8;
    expect_out("t1_w_stall", F_STALL, 0);
    expect_out("t1_w_fw",    F_FWDRS, 1);
    cyc(); idle();
    hif.M_A3 = 5'd8; hif.M_Tnew = 2'd1; hif.D_A1 = 5'd8; hif.D_rs_Tuse = 2'd1;
    expect_out("t1_eq_stall", F_STALL, 0);
    cyc(); idle();
    hif.E_A3 = 5'd8; hif.E_Tnew = 2'd2; hif.D_A1 = 5'd8; hif.D_rs_Tuse = 2'd1;
    expect_out("t1_gt_stall", F_STALL, 1);
    expect_out("t1_gt_flush", F_FLUSH, 1);
    cyc(); idle();
    hif.M_A3 = 5'd9; hif.M_Tnew = 2'd1; hif.D_A2 = 5'd9;
    expect_out("t1_cnt3",     F_CNT,   3);
    expect_out("t1_rt_stall", F_STALL, 1);
    expect_out("t1_rt_fw",    F_FWDRT, 0);

    // D forwarding priority
    cyc(); idle();
    hif.E_A3 = 5'd5; hif.M_A3 = 5'd5; hif.W_A3 = 5'd5; hif.D_A2 = 5'd5;
    expect_out("t2_cnt4",  F_CNT,   4);
    expect_out("t2_e_win", F_FWDRT, 3);
    expect_out("t2_nostl", F_STALL, 0);
    cyc();
    hif.E_A3 = 5'd0;
    expect_out("t2_m_win", F_FWDRT, 2);
    cyc();
    hif.D_A2 = 5'd0;
    expect_out("t2_zero", F_FWDRT, 0);
    cyc(); idle();
    hif.E_A3 = 5'd5; hif.E_Tnew = 2'd1; hif.M_A3 = 5'd5;
    hif.D_A2 = 5'd5; hif.D_rt_Tuse = 2'd1;
    expect_out("t2_enotrdy_fw",  F_FWDRT, 2);
    expect_out("t2_enotrdy_stl", F_STALL, 0);

    // E forwarding priority
    cyc(); idle();
    hif.E_A1 = 5'd4; hif.E_A2 = 5'd4; hif.M_A3 = 5'd4; hif.W_A3 = 5'd4;
    expect_out("t2_ers_m", F_FWERS, 2);
    expect_out("t2_ert_m", F_FWERT, 2);
    cyc();
    hif.M_Tnew = 2'd1;
    expect_out("t2_ers_w", F_FWERS, 1);
    expect_out("t2_ert_w", F_FWERT, 1);
    cyc();
    hif.E_A1 = 5'd0;
    expect_out("t2_ers_0", F_FWERS, 0);
    expect_out("t2_ert_w2", F_FWERT, 1);

    // store-data forwarding
    cyc(); idle();
    hif.M_A2 = 5'd9; hif.W_A3 = 5'd9;
    expect_out("t6_fwm_1", F_FWMRT, 1);
    cyc();
    hif.W_A3 = 5'd0;
    expect_out("t6_fwm_0", F_FWMRT, 0);
    cyc();
    hif.M_A2 = 5'd0;
    expect_out("t6_fwm_z", F_FWMRT, 0);

    // mult then md-user held in D: 1 + 5 stall cycles
    cyc(); idle();
    hif.E_md_start = 1'b1; hif.D_md_use = 1'b1;
    expect_out("t3_stall_0", F_STALL, 1);
    expect_out("t3_busy_0",  F_BUSY,  1);
    for (int k = 1; k <= 5; k++) begin
      cyc(); idle();
      hif.D_md_use = 1'b1;
      expect_out($sformatf("t3_stall_%0d", k), F_STALL, 1);
      expect_out($sformatf("t3_busy_%0d", k),  F_BUSY,  1);
    end
    cyc(); idle();
    hif.D_md_use = 1'b1;
    expect_out("t3_stall_end", F_STALL, 0);
    expect_out("t3_busy_end",  F_BUSY,  0);

    // divide aborted by reset
    cyc(); idle();
    hif.E_md_start = 1'b1; hif.E_md_div = 1'b1;
    expect_out("t4_busy_s", F_BUSY,  1);
    expect_out("t4_stl_s",  F_STALL, 0);
    for (int k = 1; k <= 2; k++) begin
      cyc(); idle();
      expect_out($sformatf("t4_busy_%0d", k), F_BUSY, 1);
    end
    cyc(); idle();
    reset = 1'b0; hif.D_md_use = 1'b1;
    expect_out("t4_rst_busy", F_BUSY,  0);
    expect_out("t4_rst_stl",  F_STALL, 0);
    cyc(); idle();
    reset = 1'b1; hif.D_md_use = 1'b1;
    expect_out("t4_post_busy", F_BUSY,  0);
    expect_out("t4_post_stl",  F_STALL, 0);

    // full divide with no md-user in D
    cyc(); idle();
    hif.E_md_start = 1'b1; hif.E_md_div = 1'b1;
    expect_out("t4_div_busy_0", F_BUSY,  1);
    expect_out("t4_div_stl_0",  F_STALL, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(); idle();
      expect_out($sformatf("t4_div_busy_%0d", k), F_BUSY,  1);
      expect_out($sformatf("t4_div_stl_%0d", k),  F_STALL, 0);
    end
    cyc(); idle();
    expect_out("t4_div_busy_end", F_BUSY, 0);

    // saturation of a 4-bit stall counter
    cyc(); idle();
    reset = 1'b0;
    for (int j = 0; j < 20; j++) begin
      cyc(); idle();
      reset = 1'b1;
      hif.E_A3 = 5'd8; hif.E_Tnew = 2'd2; hif.D_A1 = 5'd8;
      expect_out($sformatf("t5_cnt_%0d", j), F_CNT, (j < 15) ? j : 15);
    end
    cyc(); idle();
    expect_out("t5_cnt_hold",  F_CNT,   15);
    expect_out("t5_stall_off", F_STALL, 0);
    cyc();
    expect_out("t5_cnt_hold2", F_CNT, 15);

    cyc();
    if (sb.size() != 0) chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
